// File: rtl/eth_tx_scheduler_pkg.sv
// Shared types and constants for the Ethernet TX scheduler.
// Optional statistics counters are enabled with ETH_TX_SCHED_STATS_EN.
package eth_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        GRANT = 3'd2,
        WAIT  = 3'd3,
        XFER  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam int BYTE_W_DEF    = 15;
    localparam int MAX_PAYLOAD   = 1470;
    localparam int SPLIT_PAYLOAD = 1410;
    localparam int CH_IDX_W      = 3;

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Channel-side and MAC-side signal bundle of the TX scheduler.
// slave = scheduler view, master = channel/MAC (or testbench) view.
interface eth_tx_sched_if
    import eth_tx_sched_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int BYTE_W = BYTE_W_DEF
);
    logic [N_CH-1:0]        i_req;
    logic [N_CH-1:0]        i_valid;
    logic [N_CH*8-1:0]      i_data;
    logic [N_CH*BYTE_W-1:0] i_byte_cnt;
    logic [N_CH-1:0]        i_sof;
    logic [N_CH-1:0]        i_last;
    logic                   i_tx_ready;

    logic [N_CH-1:0]        o_busy;
    logic                   o_tx_start;
    logic [CH_IDX_W-1:0]    o_tx_ch;
    logic [BYTE_W-1:0]      o_tx_len;
    logic                   o_tx_valid;
    logic [7:0]             o_tx_data;
    logic                   o_tx_end;
    logic                   o_tx_sof;
    logic                   o_frame_last;
    logic                   o_timeout;

    modport slave (
        input  i_req, i_valid, i_data, i_byte_cnt, i_sof, i_last, i_tx_ready,
        output o_busy, o_tx_start, o_tx_ch, o_tx_len, o_tx_valid, o_tx_data,
               o_tx_end, o_tx_sof, o_frame_last, o_timeout
    );

    modport master (
        output i_req, i_valid, i_data, i_byte_cnt, i_sof, i_last, i_tx_ready,
        input  o_busy, o_tx_start, o_tx_ch, o_tx_len, o_tx_valid, o_tx_data,
               o_tx_end, o_tx_sof, o_frame_last, o_timeout
    );

endinterface

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr+1,
// wrapping, so the previous winner has lowest priority.
module rr_arbiter
    import eth_tx_sched_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]     req_i,
    input  logic [CH_IDX_W-1:0] ptr_i,
    output logic [N_CH-1:0]     grant_oh_o,
    output logic [CH_IDX_W-1:0] grant_idx_o,
    output logic                grant_vld_o
);

    logic [CH_IDX_W-1:0] cand_idx [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand_idx[gi] = CH_IDX_W'((int'(ptr_i) + gi + 1) % N_CH);
        end
    endgenerate

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int off = 0; off < N_CH; off++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!grant_vld_o && cand_idx[off] == CH_IDX_W'(c) && req_i[c]) begin
                    grant_vld_o   = 1'b1;
                    grant_idx_o   = CH_IDX_W'(c);
                    grant_oh_o[c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Arbitrates N packetizer channels onto one UDP/MAC TX path with IPG and timeout.
// Define ETH_TX_SCHED_STATS_EN to add per-channel packet and timeout counters.
module eth_tx_scheduler
    import eth_tx_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int IPG_CYCLES = 12,
    parameter int TIMEOUT    = 64,
    parameter int BYTE_W     = BYTE_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    eth_tx_sched_if.slave        bus
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    output logic [N_CH*16-1:0]   o_pkt_cnt,
    output logic [15:0]          o_err_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_ARB   = ARB;
    localparam logic [2:0] S_GRANT = GRANT;
    localparam logic [2:0] S_WAIT  = WAIT;
    localparam logic [2:0] S_XFER  = XFER;
    localparam logic [2:0] S_GAP   = GAP;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(IPG_CYCLES + 1);

    logic [2:0]          state_q, state_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic [CH_IDX_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]     busy_q, busy_d;
    logic                start_q, start_d;
    logic [BYTE_W-1:0]   len_q, len_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                end_q, end_d;
    logic                sof_q, sof_d;
    logic                fl_q, fl_d;
    logic                fl_seen_q, fl_seen_d;
    logic                timeout_q, timeout_d;
    logic [BYTE_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic [N_CH-1:0]     arb_oh;
    logic [CH_IDX_W-1:0] arb_idx;
    logic                arb_vld;

    logic                sel_valid, sel_sof, sel_last;
    logic [7:0]          sel_data;
    logic [BYTE_W-1:0]   sel_cnt;

    rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
        .req_i       (bus.i_req),
        .ptr_i       (ptr_q),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    // Only the granted channel's lanes are ever looked at; others are ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_sof   = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_cnt   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == CH_IDX_W'(k)) begin
                sel_valid = bus.i_valid[k];
                sel_sof   = bus.i_sof[k];
                sel_last  = bus.i_last[k];
                sel_data  = bus.i_data[k*8 +: 8];
                sel_cnt   = bus.i_byte_cnt[k*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        ptr_d      = ptr_q;
        busy_d     = '1;
        start_d    = 1'b0;
        len_d      = len_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        end_d      = 1'b0;
        sof_d      = sof_q;
        fl_d       = 1'b0;
        fl_seen_d  = fl_seen_q;
        timeout_d  = 1'b0;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (|bus.i_req && bus.i_tx_ready) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_vld) begin
                    ch_d    = arb_idx;
                    ptr_d   = arb_idx;
                    busy_d  = ~arb_oh;
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                wait_cnt_d = '0;
                fl_seen_d  = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (sel_valid) begin
                    len_d      = sel_cnt;
                    sof_d      = sel_sof;
                    start_d    = 1'b1;
                    valid_d    = 1'b1;
                    data_d     = sel_data;
                    beat_cnt_d = BYTE_W'(1);
                    if (sel_cnt <= BYTE_W'(1)) begin
                        end_d     = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        state_d   = S_XFER;
                    end
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                if (sel_valid) begin
                    valid_d    = 1'b1;
                    data_d     = sel_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == len_q - BYTE_W'(1)) begin
                        end_d     = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(IPG_CYCLES - 1)) state_d = S_IDLE;
                else                                     gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // i_last may trail the final beat by a couple of cycles, hence the early-GAP window.
        if ((state_q == S_WAIT || state_q == S_XFER ||
             (state_q == S_GAP && gap_cnt_q < GAP_W'(3))) && sel_last && !fl_seen_q) begin
            fl_d      = 1'b1;
            fl_seen_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            ptr_q      <= '0;
            busy_q     <= '1;
            start_q    <= 1'b0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            end_q      <= 1'b0;
            sof_q      <= 1'b0;
            fl_q       <= 1'b0;
            fl_seen_q  <= 1'b0;
            timeout_q  <= 1'b0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            end_q      <= end_d;
            sof_q      <= sof_d;
            fl_q       <= fl_d;
            fl_seen_q  <= fl_seen_d;
            timeout_q  <= timeout_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_tx_start   = start_q;
    assign bus.o_tx_ch      = ch_q;
    assign bus.o_tx_len     = len_q;
    assign bus.o_tx_valid   = valid_q;
    assign bus.o_tx_data    = data_q;
    assign bus.o_tx_end     = end_q;
    assign bus.o_tx_sof     = sof_q;
    assign bus.o_frame_last = fl_q;
    assign bus.o_timeout    = timeout_q;

`ifdef ETH_TX_SCHED_STATS_EN
    logic [15:0] pkt_cnt_q [N_CH];
    logic [15:0] err_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_pkt_cnt
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)                                   pkt_cnt_q[gi] <= '0;
                else if (end_d && ch_q == CH_IDX_W'(gi))        pkt_cnt_q[gi] <= pkt_cnt_q[gi] + 1'b1;
            end
            assign o_pkt_cnt[gi*16 +: 16] = pkt_cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                              err_cnt_q <= '0;
        else if (timeout_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
    end
    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: packet-vector table plus reset/timeout sequences.
module tb_eth_tx_scheduler;

    localparam int N_CH   = 4;
    localparam int BYTE_W = 15;
    localparam int IPG    = 12;

    typedef struct {
        logic [N_CH-1:0] mask;
        int              len;
        bit              sof;
        bit              last;
        int              extra;
        int              exp_ch;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_g = 0;
    int   prev_end = -1;

    always #4 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    eth_tx_sched_if #(.N_CH(N_CH), .BYTE_W(BYTE_W)) bus ();

`ifdef ETH_TX_SCHED_STATS_EN
    logic [N_CH*16-1:0] pkt_cnt;
    logic [15:0]        err_cnt;
`endif

    eth_tx_scheduler #(
        .N_CH(N_CH), .IPG_CYCLES(IPG), .TIMEOUT(64), .BYTE_W(BYTE_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef ETH_TX_SCHED_STATS_EN
        ,
        .o_pkt_cnt (pkt_cnt),
        .o_err_cnt (err_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_g);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic logic [7:0] pat(input int ch, input int n);
        return 8'((n * 7 + ch * 33) & 255);
    endfunction

    function automatic int low_idx(input logic [N_CH-1:0] busy);
        int idx = -1;
        for (int k = 0; k < N_CH; k++) if (!busy[k]) idx = k;
        return idx;
    endfunction

    task automatic set_chan(input logic [N_CH-1:0] mask, input int len, input bit sof);
        bus.i_req   = mask;
        bus.i_valid = '0;
        bus.i_last  = '0;
        bus.i_data  = '0;
        bus.i_sof   = sof ? '1 : '0;
        for (int k = 0; k < N_CH; k++) bus.i_byte_cnt[k*BYTE_W +: BYTE_W] = BYTE_W'(len);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.o_busy), 15);
        chk({tag, "_pulses"}, int'({bus.o_tx_start, bus.o_tx_valid, bus.o_tx_end,
                                    bus.o_frame_last, bus.o_timeout, bus.o_tx_sof}), 0);
        chk({tag, "_tx_ch"}, int'(bus.o_tx_ch), 0);
        chk({tag, "_tx_len"}, int'(bus.o_tx_len), 0);
        chk({tag, "_tx_data"}, int'(bus.o_tx_data), 0);
    endtask

    // One complete packet: grant, stream len+extra beats, watch the first part of the gap.
    task automatic run_vec(input vec_t v, input string tag);
        int t0 = cyc_g;
        int g = -1, grant_at = -1, busy_low = 0;
        int starts = 0, st_ch = -1, st_len = -1, st_sof = -1, end_sof = -1;
        int beats = 0, ends = 0, end_beat = -1, end_at = -1;
        int fls = 0, tos = 0, data_err = 0, strays = 0, sent = 0;
        set_chan(v.mask, v.len, v.sof);
        bus.i_tx_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.o_busy != '1) begin
                busy_low++;
                if (g < 0) begin g = low_idx(bus.o_busy); grant_at = cyc_g; end
            end
            if (bus.o_tx_start) begin
                starts++;
                st_ch = int'(bus.o_tx_ch); st_len = int'(bus.o_tx_len); st_sof = int'(bus.o_tx_sof);
            end
            if (bus.o_tx_valid) begin
                if (end_at >= 0) strays++;
                else begin
                    if (bus.o_tx_data != pat(g, beats)) data_err++;
                    beats++;
                end
            end
            if (bus.o_tx_end) begin
                ends++; end_beat = beats; end_at = cyc_g; end_sof = int'(bus.o_tx_sof);
            end
            fls += int'(bus.o_frame_last);
            tos += int'(bus.o_timeout);
            bus.i_valid = '0;
            bus.i_last  = '0;
            if (g >= 0 && cyc_g >= grant_at + 2 && sent < v.len + v.extra) begin
                bus.i_valid[g]        = 1'b1;
                bus.i_data[g*8 +: 8]  = pat(g, sent);
                bus.i_last[g]         = v.last && (sent == v.len - 1);
                sent++;
            end
            if (end_at >= 0 && cyc_g >= end_at + 4) break;
        end
        $display("pkt %s: ch=%0d len=%0d beats=%0d grant@%0d end@%0d", tag, g, st_len, beats, grant_at, end_at);
        chk({tag, "_grant_ch"}, g, v.exp_ch);
        chk({tag, "_busy_low_cycles"}, busy_low, 1);
        if (prev_end >= 0) chk({tag, "_ipg_to_grant"}, grant_at - prev_end, IPG + 2);
        else               chk({tag, "_arb_latency"}, grant_at - t0, 2);
        chk({tag, "_starts"}, starts, 1);
        chk({tag, "_tx_ch"}, st_ch, v.exp_ch);
        chk({tag, "_tx_len"}, st_len, v.len);
        chk({tag, "_tx_sof"}, st_sof, int'(v.sof));
        chk({tag, "_sof_at_end"}, end_sof, int'(v.sof));
        chk({tag, "_beats"}, beats, v.len);
        chk({tag, "_ends"}, ends, 1);
        chk({tag, "_end_beat"}, end_beat, v.len);
        chk({tag, "_data_err"}, data_err, 0);
        chk({tag, "_strays"}, strays, 0);
        chk({tag, "_frame_last"}, fls, int'(v.last));
        chk({tag, "_timeouts"}, tos, 0);
        prev_end = end_at;
    endtask

    initial begin
        vec_t vecs[9];
        vec_t post;
        int g, grant_at, to_at, tos, busy_low, starts, beats, sent, bad;

        vecs[0] = '{4'b1111,  100, 1'b0, 1'b0, 0, 1};
        vecs[1] = '{4'b1111,  100, 1'b0, 1'b0, 0, 2};
        vecs[2] = '{4'b1111,  100, 1'b0, 1'b0, 0, 3};
        vecs[3] = '{4'b1111,  100, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{4'b0100, 1410, 1'b0, 1'b0, 0, 2};
        vecs[5] = '{4'b0001,   60, 1'b1, 1'b1, 2, 0};
        vecs[6] = '{4'b0001,    1, 1'b0, 1'b0, 0, 0};
        vecs[7] = '{4'b1010,    5, 1'b0, 1'b0, 0, 1};
        vecs[8] = '{4'b1001,    3, 1'b0, 1'b1, 0, 3};

        // Reset state and quiescent IDLE.
        set_chan('0, 0, 1'b0);
        bus.i_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_busy != '1 || bus.o_tx_start || bus.o_tx_valid || bus.o_timeout) bad++;
        end
        chk("idle_no_req_activity", bad, 0);

        // Requests pending but MAC not ready: no grant.
        bus.i_req = 4'b0001;
        bus.i_tx_ready = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_busy != '1) bad++;
        end
        chk("not_ready_no_grant", bad, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Timeout: grant with no data ever arriving.
        set_chan(4'b0010, 10, 1'b0);
        g = -1; grant_at = -1; to_at = -1; tos = 0; busy_low = 0; starts = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.o_busy != '1) begin
                busy_low++;
                if (g < 0) begin g = low_idx(bus.o_busy); grant_at = cyc_g; end
            end
            if (bus.o_tx_start) starts++;
            if (bus.o_timeout) begin tos++; if (to_at < 0) to_at = cyc_g; end
            if (to_at >= 0) bus.i_req = '0;
            if (to_at >= 0 && cyc_g >= to_at + 20) break;
        end
        $display("timeout seq: ch=%0d grant@%0d timeout@%0d", g, grant_at, to_at);
        chk("to_grant_ch", g, 1);
        chk("to_ipg_to_grant", grant_at - prev_end, IPG + 2);
        chk("to_delay", to_at - grant_at, 65);
        chk("to_pulses", tos, 1);
        chk("to_busy_low_cycles", busy_low, 1);
        chk("to_starts", starts, 0);
`ifdef ETH_TX_SCHED_STATS_EN
        chk("stats_err_cnt", int'(err_cnt), 1);
`endif
        prev_end = -1;
        post = '{4'b0011, 4, 1'b0, 1'b0, 0, 0};
        run_vec(post, "after_to");

        // Asynchronous reset in the middle of a 1410-byte packet.
        set_chan(4'b0100, 1410, 1'b0);
        g = -1; grant_at = -1; beats = 0; sent = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.o_busy != '1 && g < 0) begin g = low_idx(bus.o_busy); grant_at = cyc_g; end
            if (bus.o_tx_valid) beats++;
            bus.i_valid = '0;
            if (g >= 0 && cyc_g >= grant_at + 2) begin
                bus.i_valid[g]       = 1'b1;
                bus.i_data[g*8 +: 8] = pat(g, sent);
                sent++;
            end
            if (beats == 500) begin
                rst_n = 1'b0;
                #1;
                break;
            end
        end
        $display("reset seq: ch=%0d beats before reset=%0d", g, beats);
        chk("rst_seq_grant_ch", g, 2);
        chk("rst_seq_beats", beats, 500);
        check_reset_outputs("async_rst");
        set_chan('0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        prev_end = -1;
        post = '{4'b1111, 5, 1'b1, 1'b0, 0, 1};
        run_vec(post, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
